// File: rtl/flit_type_control_fsm.sv
// rtl/flit_type_control_fsm.sv - per-input-port wormhole control FSM, packet boundaries from FlitType.
// Optional build macro PACKET_LEN_CHECK_EN adds sticky protoError for bad types and over-length packets.
module flit_type_control_fsm #(
  parameter int PhitPerFlit      = 2,
  parameter int TYPE_WIDTH       = 2,
  parameter int MaxFlitPerPacket = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic [TYPE_WIDTH-1:0]        FlitType,
  output logic                         valid_out,
  input  logic                         ready_out,
  input  logic [TYPE_WIDTH-1:0]        outFlitType,
  output logic                         reserveRoute,
  input  logic                         routeReserveStatus,
  output logic                         headFlitValid,
  output logic [$clog2(PhitPerFlit):0] phitCounter,
  output logic                         pushBuffer,
  output logic                         popBuffer,
  output logic                         Handshake,
  input  logic                         full,
  input  logic                         empty,
  output logic                         routeRelieve,
  output logic                         protoError
);

  localparam int PcW = $clog2(PhitPerFlit) + 1;
  localparam int FcW = $clog2(MaxFlitPerPacket + 1);
  localparam logic [PcW-1:0]        LastPhitIdx  = PcW'(PhitPerFlit - 1);
  localparam logic [FcW-1:0]        MaxFlits     = FcW'(MaxFlitPerPacket);
  localparam logic [TYPE_WIDTH-1:0] TypeHeadTail = TYPE_WIDTH'(0);
  localparam logic [TYPE_WIDTH-1:0] TypeTail     = TYPE_WIDTH'(3);

  typedef enum logic [1:0] {Idle, Reserve, Route, Drain} stateT;

  stateT                 state, nextState;
  logic [FcW-1:0]        flitCounter;
  logic [TYPE_WIDTH-1:0] curType, effType;
  logic [PcW-1:0]        outPhitCnt;
  logic                  relievePending;
  logic                  firstPhit, lastPhit, acceptState, dropFlit, tailOut;

  assign valid_out   = ~empty;
  assign popBuffer   = valid_out & ready_out;
  assign firstPhit   = (phitCounter == '0);
  assign effType     = firstPhit ? FlitType : curType;
  assign acceptState = (state == Idle) | (state == Route);

  // Push and pop on a full FIFO is only safe once the route is held; a dropped flit never needs space.
  assign ready_in   = ~rst & valid_in & acceptState &
                      (~full | ((state == Route) & popBuffer) | dropFlit);
  assign Handshake  = valid_in & ready_in;
  assign lastPhit   = Handshake & (phitCounter == LastPhitIdx);
  assign pushBuffer = Handshake & ~dropFlit;

  assign tailOut      = (outFlitType == TypeTail) | (outFlitType == TypeHeadTail);
  assign routeRelieve = ~rst & popBuffer & (outPhitCnt == LastPhitIdx) & tailOut;

`ifdef PACKET_LEN_CHECK_EN
  localparam logic [TYPE_WIDTH-1:0] TypeHead = TYPE_WIDTH'(1);

  logic headType, protoSet, protoErrorQ;

  assign headType = (effType == TypeHead) | (effType == TypeHeadTail);
  assign dropFlit = (state == Idle) & ~headType;
  assign protoSet = Handshake & firstPhit &
                    (((state == Idle) & ~headType) |
                     ((state == Route) & (headType | (flitCounter == MaxFlits))));

  always_ff @(posedge clk) begin
    if (rst) begin
      protoErrorQ <= 1'b0;
    end else if (protoSet) begin
      protoErrorQ <= 1'b1;
    end
  end

  assign protoError = protoErrorQ;
`else
  assign dropFlit   = 1'b0;
  assign protoError = 1'b0;
`endif

  always_comb begin
    nextState     = state;
    reserveRoute  = 1'b0;
    headFlitValid = 1'b0;
    unique case (state)
      Idle: begin
        if (lastPhit & ~dropFlit) begin
          headFlitValid = 1'b1;
          nextState     = Reserve;
        end
      end
      Reserve: begin
        reserveRoute = ~rst;
        if (routeReserveStatus) begin
          // A single-flit packet may already have left the FIFO while the grant was pending.
          if (curType == TypeHeadTail) begin
            nextState = (relievePending | routeRelieve) ? Idle : Drain;
          end else begin
            nextState = Route;
          end
        end
      end
      Route: begin
        if (lastPhit & (effType == TypeTail)) begin
          nextState = Drain;
        end
      end
      Drain: begin
        if (routeRelieve | relievePending) begin
          nextState = Idle;
        end
      end
      default: nextState = Idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= Idle;
      phitCounter    <= '0;
      flitCounter    <= '0;
      curType        <= '0;
      outPhitCnt     <= '0;
      relievePending <= 1'b0;
    end else begin
      state <= nextState;
      if (Handshake) begin
        phitCounter <= (phitCounter == LastPhitIdx) ? '0 : phitCounter + PcW'(1);
        if (firstPhit) begin
          curType <= FlitType;
        end
      end
      if (popBuffer) begin
        outPhitCnt <= (outPhitCnt == LastPhitIdx) ? '0 : outPhitCnt + PcW'(1);
      end
      if ((state == Idle) && lastPhit && !dropFlit) begin
        flitCounter <= FcW'(1);
      end else if ((state == Route) && lastPhit && (flitCounter != MaxFlits)) begin
        flitCounter <= flitCounter + FcW'(1);
      end
      if (nextState == Idle) begin
        relievePending <= 1'b0;
      end else if ((state == Reserve) && routeRelieve) begin
        relievePending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flit_type_control_fsm.sv
// tb/tb_flit_type_control_fsm.sv - self-checking bench for flit_type_control_fsm (PhitPerFlit=2).
module tb_flit_type_control_fsm;
  localparam int P     = 2;
  localparam int TW    = 2;
  localparam int MaxF  = 4;
  localparam int Depth = 4;
  localparam int PcW   = $clog2(P) + 1;
  localparam logic [1:0] THT = 2'd0, TH = 2'd1, TP = 2'd2, TT = 2'd3;
  localparam bit Lo = 1'b0, Hi = 1'b1;
`ifdef PACKET_LEN_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic valid_in = 1'b0, ready_out = 1'b0, routeReserveStatus = 1'b0, full = 1'b0, empty = 1'b1;
  logic [TW-1:0] FlitType = '0, outFlitType = '0;
  logic ready_in, valid_out, reserveRoute, headFlitValid, pushBuffer, popBuffer;
  logic Handshake, routeRelieve, protoError;
  logic [PcW-1:0] phitCounter;

  flit_type_control_fsm #(.PhitPerFlit(P), .TYPE_WIDTH(TW), .MaxFlitPerPacket(MaxF)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in), .FlitType(FlitType),
    .valid_out(valid_out), .ready_out(ready_out), .outFlitType(outFlitType),
    .reserveRoute(reserveRoute), .routeReserveStatus(routeReserveStatus),
    .headFlitValid(headFlitValid), .phitCounter(phitCounter), .pushBuffer(pushBuffer),
    .popBuffer(popBuffer), .Handshake(Handshake), .full(full), .empty(empty),
    .routeRelieve(routeRelieve), .protoError(protoError));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ftype;
    bit headLast, pktLast, flitLast, isHT, firstPhit;
    int flitIdx;
  } phitT;

  typedef struct {
    logic v; logic [1:0] ft; logic fl, em, ro;
    logic eRdy, ePush, eVo, ePop;
  } vecT;

  phitT txQ[$];
  phitT fifoQ[$];
  int   relCyc[$];
  int   pktStart[$];

  int nChecks = 0, nFails = 0, cyc = 0;
  int validPct = 100, readyPct = 100, grantDelay = 0, waitCnt = 0;
  bit randGrant = 0;
  bit blocked = 0, inBody = 0, awaitGrant = 0, gotGrant = 0, awaitRelieve = 0, gotRelieve = 0;
  bit curHT = 0, protoExp = 0;
  int hsCount = 0;
  int heads, pushes, pops, relieves, relievePopIdx, stalls, reserveCycles, fullPushPop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vecT mkVec(logic v, logic [1:0] ft, logic fl, logic em, logic ro,
                                logic eRdy, logic ePush, logic eVo, logic ePop);
    vecT r;
    r.v = v; r.ft = ft; r.fl = fl; r.em = em; r.ro = ro;
    r.eRdy = eRdy; r.ePush = ePush; r.eVo = eVo; r.ePop = ePop;
    return r;
  endfunction

  task automatic addPacket(input int nFlits);
    phitT ph;
    for (int f = 0; f < nFlits; f++) begin
      for (int p = 0; p < P; p++) begin
        ph.ftype     = (nFlits == 1) ? THT : (f == 0) ? TH : (f == nFlits - 1) ? TT : TP;
        ph.headLast  = (f == 0) && (p == P - 1);
        ph.pktLast   = (f == nFlits - 1) && (p == P - 1);
        ph.flitLast  = (p == P - 1);
        ph.isHT      = (nFlits == 1);
        ph.firstPhit = (p == 0);
        ph.flitIdx   = f + 1;
        txQ.push_back(ph);
      end
    end
  endtask

  task automatic clearStats();
    heads = 0; pushes = 0; pops = 0; relieves = 0; relievePopIdx = 0;
    stalls = 0; reserveCycles = 0; fullPushPop = 0;
    relCyc.delete(); pktStart.delete();
  endtask

  // One clock of stimulus plus the packet-level reference: acceptance is blocked from head
  // completion until grant, and after a packet's last phit until both grant and relieve were seen.
  task automatic cycle();
    phitT cur;
    bit pop, hs, expReady, expRelieve;
    @(negedge clk);
    cyc++;
    full  = (fifoQ.size() >= Depth);
    empty = (fifoQ.size() == 0);
    outFlitType = empty ? 2'($urandom) : fifoQ[0].ftype;
    ready_out = ($urandom_range(99) < readyPct);
    if (txQ.size() > 0 && $urandom_range(99) < validPct) begin
      valid_in = 1'b1; FlitType = txQ[0].ftype;
    end else begin
      valid_in = 1'b0; FlitType = 2'($urandom);
    end
    routeReserveStatus = reserveRoute && (waitCnt >= grantDelay);
    #1;
    pop = !empty && ready_out;
    hs  = valid_in && ready_in;
    expReady   = blocked ? 1'b0 : (valid_in && (!full || (inBody && pop)));
    expRelieve = pop && fifoQ[0].flitLast && (fifoQ[0].ftype inside {THT, TT});
    check("ready_in", ready_in, expReady);
    check("Handshake", Handshake, hs);
    check("pushBuffer", pushBuffer, hs);
    check("valid_out", valid_out, !empty);
    check("popBuffer", popBuffer, pop);
    check("phitCounter", phitCounter, hsCount % P);
    check("reserveRoute", reserveRoute, awaitGrant);
    check("headFlitValid", headFlitValid, hs && txQ[0].headLast);
    check("routeRelieve", routeRelieve, expRelieve);
    check("protoError", protoError, protoExp);

    if (valid_in && !ready_in) stalls++;
    if (reserveRoute) reserveCycles++;
    if (headFlitValid) heads++;
    if (full && hs && pop) fullPushPop++;

    if (awaitGrant) begin
      if (routeReserveStatus) begin
        awaitGrant = 0; gotGrant = 1; waitCnt = 0;
        if (randGrant) grantDelay = $urandom_range(0, 3);
        if (!curHT) begin inBody = 1; blocked = 0; end
      end else begin
        waitCnt++;
      end
    end
    if (pop) begin
      void'(fifoQ.pop_front());
      pops++;
    end
    if (hs) begin
      cur = txQ.pop_front();
      hsCount++;
      pushes++;
      fifoQ.push_back(cur);
      if (cur.firstPhit && cur.flitIdx == 1) pktStart.push_back(cyc);
      if (CheckEn && cur.firstPhit && cur.flitIdx > MaxF) protoExp = 1;
      if (cur.headLast) begin
        blocked = 1; awaitGrant = 1; curHT = cur.isHT; gotGrant = 0; gotRelieve = 0; waitCnt = 0;
      end
      if (cur.pktLast) begin
        blocked = 1; inBody = 0; awaitRelieve = 1;
      end
    end
    if (expRelieve) begin
      gotRelieve = 1; relieves++; relievePopIdx = pops; relCyc.push_back(cyc);
    end
    if (awaitRelieve && gotRelieve && gotGrant) begin
      awaitRelieve = 0; blocked = 0;
    end
  endtask

  task automatic runUntilDone(input string name, input int maxCyc);
    int n = 0;
    while ((txQ.size() > 0 || blocked || awaitGrant || fifoQ.size() > 0) && n < maxCyc) begin
      cycle();
      n++;
    end
    check({name, " completes"}, n < maxCyc, 1'b1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b1; FlitType = TH; ready_out = 1'b1; routeReserveStatus = 1'b0;
    full = 1'b0; empty = 1'b0; outFlitType = TT;
    #1;
    check("rst ready_in", ready_in, 1'b0);
    check("rst pushBuffer", pushBuffer, 1'b0);
    check("rst reserveRoute", reserveRoute, 1'b0);
    check("rst headFlitValid", headFlitValid, 1'b0);
    check("rst routeRelieve", routeRelieve, 1'b0);
    check("rst valid_out", valid_out, 1'b1);
    @(negedge clk);
    #1;
    check("rst phitCounter", phitCounter, 0);
    check("rst protoError", protoError, 1'b0);
    check("rst reserveRoute held", reserveRoute, 1'b0);
    rst = 1'b0; valid_in = 1'b0; empty = 1'b1; ready_out = 1'b0;
    txQ.delete(); fifoQ.delete();
    blocked = 0; inBody = 0; awaitGrant = 0; gotGrant = 0; awaitRelieve = 0; gotRelieve = 0;
    hsCount = 0; protoExp = 0; waitCnt = 0;
  endtask

  initial begin
    vecT vecs[9];
    int n;
    vecs[0] = mkVec(Hi, TH, Lo, Hi, Lo, Hi, Hi, Lo, Lo);
    vecs[1] = mkVec(Hi, TH, Hi, Lo, Lo, Lo, Lo, Hi, Lo);
    vecs[2] = mkVec(Hi, TH, Hi, Lo, Hi, Lo, Lo, Hi, Hi);
    vecs[3] = mkVec(Lo, TH, Lo, Lo, Hi, Lo, Lo, Hi, Hi);
    vecs[4] = mkVec(Lo, TH, Lo, Hi, Hi, Lo, Lo, Lo, Lo);
    vecs[5] = mkVec(Hi, TH, Lo, Lo, Hi, Hi, Hi, Hi, Hi);
    vecs[6] = mkVec(Hi, THT, Lo, Lo, Lo, Hi, Hi, Hi, Lo);
    vecs[7] = mkVec(Lo, TH, Hi, Lo, Lo, Lo, Lo, Hi, Lo);
    vecs[8] = mkVec(Hi, TP, Lo, Hi, Lo, Hi, !CheckEn, Lo, Lo);

    clearStats();
    doReset();

    // Combinational behaviour in IDLE; inputs are withdrawn before each edge so state holds.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      valid_in = vecs[i].v; FlitType = vecs[i].ft; full = vecs[i].fl; empty = vecs[i].em;
      ready_out = vecs[i].ro; outFlitType = THT; routeReserveStatus = 1'b0;
      #1;
      check($sformatf("vec%0d ready_in", i), ready_in, vecs[i].eRdy);
      check($sformatf("vec%0d pushBuffer", i), pushBuffer, vecs[i].ePush);
      check($sformatf("vec%0d valid_out", i), valid_out, vecs[i].eVo);
      check($sformatf("vec%0d popBuffer", i), popBuffer, vecs[i].ePop);
      check($sformatf("vec%0d routeRelieve", i), routeRelieve, 1'b0);
      check($sformatf("vec%0d headFlitValid", i), headFlitValid, 1'b0);
      valid_in = 1'b0; ready_out = 1'b0;
    end
    full = 1'b0; empty = 1'b1;

    // H,P,P,T with grant two cycles after reserveRoute rises.
    clearStats(); randGrant = 0; grantDelay = 2; validPct = 100; readyPct = 100;
    addPacket(4);
    runUntilDone("t1", 200);
    check("t1 heads", heads, 1);
    check("t1 stalls", stalls, 3);
    check("t1 pushes", pushes, 8);
    check("t1 relieves", relieves, 1);
    check("t1 relieve pop index", relievePopIdx, 8);

    // Single-flit packet with immediate grant.
    clearStats(); grantDelay = 0;
    addPacket(1);
    runUntilDone("t2", 200);
    check("t2 pushes", pushes, 2);
    check("t2 relieves", relieves, 1);
    check("t2 relieve pop index", relievePopIdx, 2);
    check("t2 reserve cycles", reserveCycles, 1);

    // FIFO fills while routed, then drains with simultaneous push and pop.
    clearStats(); readyPct = 0;
    addPacket(6);
    n = 0;
    while (!(inBody && fifoQ.size() == Depth) && n < 60) begin cycle(); n++; end
    check("t3 reached full in ROUTE", n < 60, 1'b1);
    cycle(); cycle();
    readyPct = 100;
    runUntilDone("t3", 200);
    check("t3 full push+pop seen", fullPushPop > 0, 1'b1);

    // Back-to-back packets: second head accepted the cycle after the first relieve.
    clearStats(); grantDelay = 1;
    addPacket(2); addPacket(3);
    runUntilDone("t4", 300);
    check("t4 relieves", relieves, 2);
    check("t4 packets started", pktStart.size(), 2);
    if (relCyc.size() > 0 && pktStart.size() > 1)
      check("t4 second head latency", pktStart[1] - relCyc[0], 1);

    // Reset in ROUTE with a flit half received.
    clearStats(); grantDelay = 0;
    addPacket(4);
    n = 0;
    while (!(inBody && (hsCount % P) == 1) && n < 50) begin cycle(); n++; end
    check("t5 reached mid-flit ROUTE", n < 50, 1'b1);
    doReset();
    @(negedge clk);
    valid_in = 1'b1; FlitType = TH; full = 1'b0; empty = 1'b1; ready_out = 1'b0;
    #1;
    check("t5 idle ready_in", ready_in, 1'b1);
    check("t5 phitCounter", phitCounter, 0);
    check("t5 reserveRoute", reserveRoute, 1'b0);
    check("t5 routeRelieve", routeRelieve, 1'b0);
    valid_in = 1'b0;

    // Five-flit packet against a four-flit limit.
    clearStats(); grantDelay = 1;
    addPacket(5);
    runUntilDone("t6", 300);
    check("t6 protoError sticky", protoError, CheckEn);
    check("t6 relieves", relieves, 1);
    doReset();

    // Random traffic, legal packet lengths.
    clearStats(); randGrant = 1; validPct = 70; readyPct = 60;
    for (int i = 0; i < 60; i++) addPacket($urandom_range(1, MaxF));
    runUntilDone("random A", 20000);
    check("random A heads", heads, 60);
    check("random A relieves", relieves, 60);

    clearStats(); validPct = 100; readyPct = 30;
    for (int i = 0; i < 40; i++) addPacket($urandom_range(1, MaxF));
    runUntilDone("random B", 20000);
    check("random B heads", heads, 40);
    check("random B relieves", relieves, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/flit_type_control_fsm.md
Name: flit_type_control_fsm

Overview:
Next-generation per-input-port wormhole control FSM for the NoC router. It detects packet boundaries from the FlitType field rather than a fixed flits-per-packet count, so packets are variable-length and may be single-flit.
- Phit width of a flit is parametrised.
- Output-side tail tracking: the route is relieved only when the last phit of the tail flit leaves the input FIFO.
- The block sits between the upstream link handshake, the input FIFO, the head-flit buffer and the switch allocator.

Parameters:
PhitPerFlit, 2, phits per flit (>=1)
TYPE_WIDTH, 2, FlitType field width
MaxFlitPerPacket, 16, max flits per packet including head; sizes flitCounter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid_in  input  1  upstream phit valid
ready_in  output  1  upstream phit ready
FlitType  input  TYPE_WIDTH  type of incoming phit's flit; sampled on first phit of a flit
valid_out  output  1  downstream phit valid
ready_out  input  1  downstream ready
outFlitType  input  TYPE_WIDTH  type of flit at FIFO head
reserveRoute  output  1  request route reservation
routeReserveStatus  input  1  route granted
headFlitValid  output  1  pulse: complete head flit captured
phitCounter  output  $clog2(PhitPerFlit)+1  input-side phit index within current flit
pushBuffer  output  1  FIFO write
popBuffer  output  1  FIFO read
Handshake  output  1  valid_in & ready_in
full  input  1  FIFO full
empty  input  1  FIFO empty
routeRelieve  output  1  pulse: tail's last phit popped
protoError  output  1  sticky protocol error (only with PACKET_LEN_CHECK_EN)

Behaviour:
- Types: 00 HEADTAIL (single-flit), 01 HEAD, 10 PAYLOAD, 11 TAIL.
- Reset: state=IDLE; phitCounter, flitCounter, curType, outPhitCnt, protoError cleared.
- On reset, reserveRoute, headFlitValid, routeRelieve, ready_in, pushBuffer are 0; valid_out follows ~empty.
- Reset mid-packet abandons the packet with no relieve pulse. The FIFO is reset by its owner.
- Handshake = valid_in & ready_in. pushBuffer = Handshake in IDLE/ROUTE. popBuffer = valid_out & ready_out. valid_out = ~empty.
- ready_in = valid_in & (IDLE|ROUTE) & (~full | (state==ROUTE & popBuffer)). Simultaneous push and pop on full is allowed only in ROUTE.
- phitCounter: increments on Handshake; wraps to 0 after PhitPerFlit-1. lastPhit = Handshake & phitCounter==PhitPerFlit-1.
- curType: latched from FlitType on Handshake when phitCounter==0. Effective type = FlitType when phitCounter==0, else curType.
- States:
  - IDLE: accepts head phits. On lastPhit: headFlitValid=1 that cycle, flitCounter=1, next RESERVE.
  - RESERVE: ready_in=0, reserveRoute=1. On routeReserveStatus: to DRAIN if head type was HEADTAIL, else to ROUTE.
  - ROUTE: accepts payload/tail. flitCounter++ (saturating at MaxFlitPerPacket) on each lastPhit. lastPhit with effective type TAIL -> DRAIN.
  - DRAIN: ready_in=0; waits for routeRelieve, then IDLE next cycle.
- Output side: outPhitCnt increments on popBuffer and wraps at PhitPerFlit-1. routeRelieve = popBuffer & outPhitCnt==PhitPerFlit-1 & outFlitType in {TAIL, HEADTAIL}.
- Latency: head last phit to reserveRoute is 1 cycle. routeRelieve to next head acceptance is 1 cycle.
- PhitPerFlit==1: every handshake is lastPhit.

Optional Feature:
PACKET_LEN_CHECK_EN
- Defined:
  - protoError set (sticky until rst) when the first-phit type in IDLE is not HEAD/HEADTAIL; that flit is consumed (ready_in=1) but not pushed.
  - protoError also set when a HEAD/HEADTAIL first phit arrives in ROUTE; that flit is pushed as-is.
  - protoError also set when flitCounter would exceed MaxFlitPerPacket; that flit is pushed as-is.
- Undefined: protoError tied 0; any type in IDLE is treated as HEAD; no length checks.

Test Plan:
1. PhitPerFlit=2, packet H,P,P,T with continuous valid, grant 2 cycles after reserveRoute, ready_out=1 -> headFlitValid pulses once; ready_in low 3 cycles; 8 pushes; routeRelieve exactly once on 8th pop; IDLE the cycle after.
2. Single-flit HEADTAIL, grant immediate -> RESERVE->DRAIN; 2 pushes; routeRelieve on 2nd pop; no ROUTE visit.
3. FIFO full in ROUTE with ready_out=1 -> ready_in=1, push and pop in the same cycle. Same condition in IDLE -> ready_in=0.
4. Back-to-back packets, second head waiting on valid_in -> second head not accepted until cycle after first routeRelieve.
5. rst asserted in ROUTE mid-flit -> next cycle state IDLE, phitCounter=0, reserveRoute=0, no routeRelieve.
6. PACKET_LEN_CHECK_EN, MaxFlitPerPacket=4, packet H,P,P,P,T -> protoError rises on 5th flit's first phit and stays high until rst.
